// File: rtl/ip_amba_axi_master_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module      : ip_amba_axi_master_cmd_arb (+ per-direction channel helper)
// Description : Round-robin AW/AR command arbiter with outstanding-burst
//               credit tracking and ID-routed completion pulses.
// Revision    : 1.0 - initial release
// ============================================================================

module ip_amba_axi_master_cmd_arb_chan #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 3,
    parameter int MAX_OUTST = 15
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*8-1:0]      i_req_len,
    input  logic [NUM_REQ*3-1:0]      i_req_size,
    input  logic [NUM_REQ*2-1:0]      i_req_burst,
    output logic [ID_W-1:0]           o_ax_id,
    output logic [ADDR_W-1:0]         o_ax_addr,
    output logic [7:0]                o_ax_len,
    output logic [2:0]                o_ax_size,
    output logic [1:0]                o_ax_burst,
    output logic                      o_ax_valid,
    input  logic                      i_ax_ready,
    input  logic                      i_cpl,
    input  logic [ID_W-1:0]           i_cpl_id,
    input  logic                      i_cpl_err,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [NUM_REQ-1:0]        o_err,
    output logic [3:0]                o_outst,
    output logic                      o_cnt_err_set
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [3:0]       c_max_outst = 4'(MAX_OUTST);
    localparam logic [IDX_W-1:0] c_last_rst  = IDX_W'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_sel;
    logic               w_found;
    logic               w_grant;
    logic               w_ax_hs;
    logic [ADDR_W-1:0]  w_addr;
    logic [7:0]         w_len;
    logic [2:0]         w_size;
    logic [1:0]         w_burst;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [NUM_REQ-1:0] w_err_nxt;

    logic [ID_W-1:0]    r_id;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len;
    logic [2:0]         r_size;
    logic [1:0]         r_burst;
    logic [3:0]         r_outst;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;

    // Two passes: requesters above last_grant first, then wrap to the rest.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (IDX_W'(i) > r_last_grant)) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req_valid[i] && (IDX_W'(i) <= r_last_grant)) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_addr  = '0;
        w_len   = '0;
        w_size  = '0;
        w_burst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                w_len   = i_req_len[i*8 +: 8];
                w_size  = i_req_size[i*3 +: 3];
                w_burst = i_req_burst[i*2 +: 2];
            end
        end
    end

    // Credit check uses the registered count, so a same-cycle completion
    // cannot open a slot.
    assign w_grant = i_rst_n && (r_state == S_IDLE) && w_found && (r_outst < c_max_outst);

    always_comb begin
        o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant && (w_sel == IDX_W'(i))) begin
                o_req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant)    w_state_nxt = S_ISSUE;
            S_ISSUE: if (i_ax_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_ax_valid = (r_state == S_ISSUE);
    assign w_ax_hs    = o_ax_valid & i_ax_ready;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_last_rst;
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_grant <= w_sel;
                r_id         <= ID_W'(w_sel);
                r_addr       <= w_addr;
                r_len        <= w_len;
                r_size       <= w_size;
                r_burst      <= w_burst;
            end
        end
    end

    assign o_cnt_err_set = i_cpl && (r_outst == 4'd0);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outst <= 4'd0;
        end else if (w_ax_hs && !i_cpl) begin
            r_outst <= r_outst + 4'd1;
        end else if (!w_ax_hs && i_cpl && (r_outst != 4'd0)) begin
            r_outst <= r_outst - 4'd1;
        end
    end

    // IDs beyond the requester range still retire a credit but pulse nobody.
    always_comb begin
        w_done_nxt = '0;
        w_err_nxt  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_cpl && (i_cpl_id == ID_W'(i))) begin
                w_done_nxt[i] = 1'b1;
                w_err_nxt[i]  = i_cpl_err;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done <= '0;
            r_err  <= '0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign o_ax_id    = r_id;
    assign o_ax_addr  = r_addr;
    assign o_ax_len   = r_len;
    assign o_ax_size  = r_size;
    assign o_ax_burst = r_burst;
    assign o_outst    = r_outst;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

module ip_amba_axi_master_cmd_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 3,
    parameter int MAX_OUTST = 15
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_REQ-1:0]        req_wvalid,
    output logic [NUM_REQ-1:0]        req_wready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
    input  logic [NUM_REQ*8-1:0]      req_wlen,
    input  logic [NUM_REQ*3-1:0]      req_wsize,
    input  logic [NUM_REQ*2-1:0]      req_wburst,
    input  logic [NUM_REQ-1:0]        req_rvalid,
    output logic [NUM_REQ-1:0]        req_rready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_raddr,
    input  logic [NUM_REQ*8-1:0]      req_rlen,
    input  logic [NUM_REQ*3-1:0]      req_rsize,
    input  logic [NUM_REQ*2-1:0]      req_rburst,
    output logic [ID_W-1:0]           AWID,
    output logic [ADDR_W-1:0]         AWADDR,
    output logic [7:0]                AWLEN,
    output logic [2:0]                AWSIZE,
    output logic [1:0]                AWBURST,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ID_W-1:0]           ARID,
    output logic [ADDR_W-1:0]         ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [ID_W-1:0]           BID,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ID_W-1:0]           RID,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    input  logic                      RREADY,
    output logic [NUM_REQ-1:0]        wr_done,
    output logic [NUM_REQ-1:0]        rd_done,
    output logic [NUM_REQ-1:0]        wr_err,
    output logic [NUM_REQ-1:0]        rd_err,
    output logic [3:0]                wr_outst,
    output logic [3:0]                rd_outst,
    output logic                      cnt_err
);

    logic w_wr_cpl;
    logic w_rd_cpl;
    logic w_wr_cnt_err;
    logic w_rd_cnt_err;
    logic w_unused;
    logic r_cnt_err;

    assign w_wr_cpl = BVALID & BREADY;
    assign w_rd_cpl = RVALID & RREADY & RLAST;
    // Only RESP[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign w_unused = ^{BRESP[0], RRESP[0]};

    ip_amba_axi_master_cmd_arb_chan #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .MAX_OUTST (MAX_OUTST)
    ) u_wr_chan (
        .clk           (ACLK),
        .i_rst_n       (ARESETn),
        .i_req_valid   (req_wvalid),
        .o_req_ready   (req_wready),
        .i_req_addr    (req_waddr),
        .i_req_len     (req_wlen),
        .i_req_size    (req_wsize),
        .i_req_burst   (req_wburst),
        .o_ax_id       (AWID),
        .o_ax_addr     (AWADDR),
        .o_ax_len      (AWLEN),
        .o_ax_size     (AWSIZE),
        .o_ax_burst    (AWBURST),
        .o_ax_valid    (AWVALID),
        .i_ax_ready    (AWREADY),
        .i_cpl         (w_wr_cpl),
        .i_cpl_id      (BID),
        .i_cpl_err     (BRESP[1]),
        .o_done        (wr_done),
        .o_err         (wr_err),
        .o_outst       (wr_outst),
        .o_cnt_err_set (w_wr_cnt_err)
    );

    ip_amba_axi_master_cmd_arb_chan #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .MAX_OUTST (MAX_OUTST)
    ) u_rd_chan (
        .clk           (ACLK),
        .i_rst_n       (ARESETn),
        .i_req_valid   (req_rvalid),
        .o_req_ready   (req_rready),
        .i_req_addr    (req_raddr),
        .i_req_len     (req_rlen),
        .i_req_size    (req_rsize),
        .i_req_burst   (req_rburst),
        .o_ax_id       (ARID),
        .o_ax_addr     (ARADDR),
        .o_ax_len      (ARLEN),
        .o_ax_size     (ARSIZE),
        .o_ax_burst    (ARBURST),
        .o_ax_valid    (ARVALID),
        .i_ax_ready    (ARREADY),
        .i_cpl         (w_rd_cpl),
        .i_cpl_id      (RID),
        .i_cpl_err     (RRESP[1]),
        .o_done        (rd_done),
        .o_err         (rd_err),
        .o_outst       (rd_outst),
        .o_cnt_err_set (w_rd_cnt_err)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cnt_err <= 1'b0;
        end else if (w_wr_cnt_err || w_rd_cnt_err) begin
            r_cnt_err <= 1'b1;
        end
    end

    assign cnt_err = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_ip_amba_axi_master_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_amba_axi_master_cmd_arb
// Description : Directed self-checking bench for the AXI command arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_ip_amba_axi_master_cmd_arb;

    localparam int NUM_REQ   = 4;
    localparam int ADDR_W    = 32;
    localparam int ID_W      = 3;
    localparam int MAX_OUTST = 15;

    logic                      ACLK = 1'b0;
    logic                      ARESETn = 1'b0;
    logic [NUM_REQ-1:0]        req_wvalid, req_wready, req_rvalid, req_rready;
    logic [NUM_REQ*ADDR_W-1:0] req_waddr, req_raddr;
    logic [NUM_REQ*8-1:0]      req_wlen, req_rlen;
    logic [NUM_REQ*3-1:0]      req_wsize, req_rsize;
    logic [NUM_REQ*2-1:0]      req_wburst, req_rburst;
    logic [ID_W-1:0]           AWID, ARID, BID, RID;
    logic [ADDR_W-1:0]         AWADDR, ARADDR;
    logic [7:0]                AWLEN, ARLEN;
    logic [2:0]                AWSIZE, ARSIZE;
    logic [1:0]                AWBURST, ARBURST, BRESP, RRESP;
    logic                      AWVALID, AWREADY, ARVALID, ARREADY;
    logic                      BVALID, BREADY, RVALID, RREADY, RLAST;
    logic [NUM_REQ-1:0]        wr_done, rd_done, wr_err, rd_err;
    logic [3:0]                wr_outst, rd_outst;
    logic                      cnt_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_grants = 0;

    always #5 ACLK = ~ACLK;

    ip_amba_axi_master_cmd_arb #(
        .NUM_REQ (NUM_REQ), .ADDR_W (ADDR_W), .ID_W (ID_W), .MAX_OUTST (MAX_OUTST)
    ) u_dut (
        .ACLK (ACLK), .ARESETn (ARESETn),
        .req_wvalid (req_wvalid), .req_wready (req_wready), .req_waddr (req_waddr),
        .req_wlen (req_wlen), .req_wsize (req_wsize), .req_wburst (req_wburst),
        .req_rvalid (req_rvalid), .req_rready (req_rready), .req_raddr (req_raddr),
        .req_rlen (req_rlen), .req_rsize (req_rsize), .req_rburst (req_rburst),
        .AWID (AWID), .AWADDR (AWADDR), .AWLEN (AWLEN), .AWSIZE (AWSIZE),
        .AWBURST (AWBURST), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .ARID (ARID), .ARADDR (ARADDR), .ARLEN (ARLEN), .ARSIZE (ARSIZE),
        .ARBURST (ARBURST), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .RID (RID), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY),
        .wr_done (wr_done), .rd_done (rd_done), .wr_err (wr_err), .rd_err (rd_err),
        .wr_outst (wr_outst), .rd_outst (rd_outst), .cnt_err (cnt_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
    endtask

    task automatic clear_inputs();
        req_wvalid = '0; req_waddr = '0; req_wlen = '0; req_wsize = '0; req_wburst = '0;
        req_rvalid = '0; req_raddr = '0; req_rlen = '0; req_rsize = '0; req_rburst = '0;
        AWREADY = 1'b0; ARREADY = 1'b0;
        BID = '0; BRESP = '0; BVALID = 1'b0; BREADY = 1'b0;
        RID = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0; RREADY = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESETn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    initial begin
        // Reset held with random inputs: every output must stay low.
        ARESETn    = 1'b0;
        req_wvalid = 4'($urandom) | 4'b0001;
        req_rvalid = 4'($urandom) | 4'b0010;
        req_waddr  = {$urandom, $urandom, $urandom, $urandom};
        req_raddr  = {$urandom, $urandom, $urandom, $urandom};
        req_wlen = 32'($urandom); req_rlen = 32'($urandom);
        req_wsize = 12'($urandom); req_rsize = 12'($urandom);
        req_wburst = 8'($urandom); req_rburst = 8'($urandom);
        AWREADY = 1'b1; ARREADY = 1'b1;
        BID = 3'($urandom); BRESP = 2'b10; BVALID = 1'b1; BREADY = 1'b1;
        RID = 3'($urandom); RRESP = 2'b11; RLAST = 1'b1; RVALID = 1'b1; RREADY = 1'b1;
        repeat (3) step();
        #1;
        check_eq("rst_wready", req_wready, 0);
        check_eq("rst_rready", req_rready, 0);
        check_eq("rst_awvalid", AWVALID, 0);
        check_eq("rst_arvalid", ARVALID, 0);
        check_eq("rst_awaddr", AWADDR, 0);
        check_eq("rst_awid", AWID, 0);
        check_eq("rst_done", {wr_done, rd_done, wr_err, rd_err}, 0);
        check_eq("rst_outst", {wr_outst, rd_outst}, 0);
        check_eq("rst_cnt_err", cnt_err, 0);

        // Fairness: all requesters active, grants rotate 0,1,2,3,0 every 2 cycles.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_waddr[i*ADDR_W +: ADDR_W] = 32'h2000_0000 + 32'(i * 16);
        req_wvalid = 4'hF;
        AWREADY    = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1 check_eq("fair_wready", req_wready, 64'(4'b0001 << (g % 4)));
            step();
            #1;
            check_eq("fair_awvalid", AWVALID, 1);
            check_eq("fair_awid", AWID, 64'(g % 4));
            check_eq("fair_awaddr", AWADDR, 64'(32'h2000_0000 + 32'((g % 4) * 16)));
            check_eq("fair_wready_issue", req_wready, 0);
            step();
        end
        req_wvalid = '0;
        #1 check_eq("fair_outst", wr_outst, 5);

        // Backpressure: payload held while AWREADY low for 5 cycles.
        do_reset();
        req_waddr[2*ADDR_W +: ADDR_W] = 32'h1000_0040;
        req_wvalid = 4'b0100;
        #1 check_eq("bp_wready", req_wready, 4'b0100);
        step();
        req_wvalid = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("bp_awvalid", AWVALID, 1);
            check_eq("bp_awaddr", AWADDR, 32'h1000_0040);
            check_eq("bp_awid", AWID, 2);
            if (k == 4) AWREADY = 1'b1;
            step();
        end
        AWREADY = 1'b0;
        #1;
        check_eq("bp_awvalid_drop", AWVALID, 0);
        check_eq("bp_outst", wr_outst, 1);

        // Same-cycle AW and B handshakes; B carries SLVERR for requester 2.
        req_wvalid = 4'b0001;
        AWREADY    = 1'b1;
        #1 check_eq("sim_wready", req_wready, 4'b0001);
        step();
        req_wvalid = '0;
        BVALID = 1'b1; BREADY = 1'b1; BID = 3'd2; BRESP = 2'b10;
        #1;
        check_eq("sim_awvalid", AWVALID, 1);
        check_eq("sim_awid", AWID, 0);
        check_eq("sim_done_early", wr_done, 0);
        step();
        BVALID = 1'b0;
        #1;
        check_eq("sim_outst", wr_outst, 1);
        check_eq("sim_wr_done", wr_done, 4'b0100);
        check_eq("sim_wr_err", wr_err, 4'b0100);
        step();
        #1;
        check_eq("sim_done_clear", wr_done, 0);
        check_eq("sim_cnt_err", cnt_err, 0);

        // Credit limit: 15 writes in flight block the 16th until a B returns.
        do_reset();
        req_wvalid = 4'b0001;
        AWREADY    = 1'b1;
        n_grants   = 0;
        for (int c = 0; c < 30; c++) begin
            #1 if (req_wready != 0) n_grants++;
            step();
        end
        check_eq("cred_grants", n_grants, 15);
        #1;
        check_eq("cred_outst_full", wr_outst, 15);
        check_eq("cred_blocked", req_wready, 0);
        step();
        BVALID = 1'b1; BREADY = 1'b1; BID = 3'd0; BRESP = 2'b00;
        #1;
        check_eq("cred_same_cycle", req_wready, 0);
        check_eq("cred_awvalid_idle", AWVALID, 0);
        step();
        BVALID = 1'b0;
        #1;
        check_eq("cred_outst_14", wr_outst, 14);
        check_eq("cred_regrant", req_wready, 4'b0001);
        check_eq("cred_done", wr_done, 4'b0001);
        step();
        req_wvalid = '0;
        #1 check_eq("cred_awvalid", AWVALID, 1);
        step();
        #1 check_eq("cred_outst_refill", wr_outst, 15);

        // Concurrent AW/AR issue, then a 4-beat read with error on the last beat.
        do_reset();
        req_raddr[1*ADDR_W +: ADDR_W] = 32'h3000_0100;
        req_rvalid = 4'b0010; ARREADY = 1'b1;
        req_wvalid = 4'b0001; AWREADY = 1'b1;
        #1;
        check_eq("rd_rready", req_rready, 4'b0010);
        check_eq("rd_wready", req_wready, 4'b0001);
        step();
        req_rvalid = '0; req_wvalid = '0;
        #1;
        check_eq("rd_arvalid", ARVALID, 1);
        check_eq("rd_arid", ARID, 1);
        check_eq("rd_araddr", ARADDR, 32'h3000_0100);
        check_eq("rd_awvalid_same", AWVALID, 1);
        step();
        #1;
        check_eq("rd_outst_1", rd_outst, 1);
        check_eq("rd_wr_outst_1", wr_outst, 1);
        RVALID = 1'b1; RREADY = 1'b1; RID = 3'd1;
        for (int b = 0; b < 4; b++) begin
            RLAST = (b == 3);
            RRESP = (b == 3) ? 2'b10 : 2'b00;
            #1;
            check_eq("rd_outst_beat", rd_outst, 1);
            check_eq("rd_done_beat", rd_done, 0);
            step();
        end
        RVALID = 1'b0;
        #1;
        check_eq("rd_outst_0", rd_outst, 0);
        check_eq("rd_done", rd_done, 4'b0010);
        check_eq("rd_err", rd_err, 4'b0010);
        step();
        #1;
        check_eq("rd_done_clear", rd_done, 0);
        check_eq("rd_cnt_err_clean", cnt_err, 0);
        RVALID = 1'b1; RLAST = 1'b1; RRESP = 2'b00; RID = 3'd1;
        step();
        RVALID = 1'b0;
        #1;
        check_eq("uf_cnt_err", cnt_err, 1);
        check_eq("uf_outst", rd_outst, 0);
        check_eq("uf_done", rd_done, 4'b0010);
        check_eq("uf_err", rd_err, 0);
        step();
        #1 check_eq("uf_sticky", cnt_err, 1);

        // Reset asserted while AWVALID is up: valid drops without a clock.
        do_reset();
        req_wvalid = 4'b1000;
        #1 check_eq("mid_wready", req_wready, 4'b1000);
        step();
        req_wvalid = '0;
        #1;
        check_eq("mid_awvalid", AWVALID, 1);
        check_eq("mid_awid", AWID, 3);
        #1 ARESETn = 1'b0;
        #1;
        check_eq("mid_awvalid_drop", AWVALID, 0);
        check_eq("mid_cnt_err_clear", cnt_err, 0);
        do_reset();
        #1;
        check_eq("mid_outst", wr_outst, 0);
        check_eq("mid_awvalid_after", AWVALID, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ip_amba_axi_master_cmd_arb.md
# ip_amba_axi_master_cmd_arb

Round-robin command arbiter and outstanding-transaction tracker for the AXI master. It sits between up to NUM_REQ application-layer requesters and the master's AW/AR channels. Write and read commands are arbitrated independently and tagged with the requester index as AXI ID. The block counts in-flight bursts per direction against a credit limit, and routes B/R completions back to the originating requester by ID.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_W, 32: address width.
- ID_W, 3: AXI ID width; ID_W >= clog2(NUM_REQ).
- MAX_OUTST, 15: max in-flight bursts per direction (1..15).

- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset; asynchronous, active-low.
- req_wvalid  in  NUM_REQ  per-requester write command valid.
- req_wready  out  NUM_REQ  one-hot write grant/accept.
- req_waddr  in  NUM_REQ*ADDR_W  packed write addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_wlen / req_wsize / req_wburst  in  NUM_REQ*8 / NUM_REQ*3 / NUM_REQ*2  packed write burst attributes.
- req_rvalid, req_rready, req_raddr, req_rlen, req_rsize, req_rburst: read-side equivalents, same widths and directions.
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID  out  ID_W, ADDR_W, 8, 3, 2, 1  AXI write address channel.
- AWREADY  in  1.
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID  out  same widths as AW*  AXI read address channel.
- ARREADY  in  1.
- BID, BRESP, BVALID, BREADY  in  ID_W, 2, 1, 1  monitored write response handshake.
- RID, RRESP, RLAST, RVALID, RREADY  in  ID_W, 2, 1, 1, 1  monitored read data handshake.
- wr_done, rd_done  out  NUM_REQ  one-cycle completion pulse to requester ID.
- wr_err, rd_err  out  NUM_REQ  one-cycle pulse with done when RESP[1]=1 (SLVERR/DECERR).
- wr_outst, rd_outst  out  4  in-flight counts.
- cnt_err  out  1  sticky; set on completion while count==0.

## Operation
- Write and read sides are identical, independent instances of the logic below. The write side is described.
- FSM states:
  - IDLE -> ISSUE when any req_wvalid is high and wr_outst < MAX_OUTST. The winner is granted in that cycle.
  - ISSUE -> IDLE on AWVALID&AWREADY.
- Round-robin arbitration:
  - Search starts at last_grant+1 modulo NUM_REQ.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority.
  - last_grant updates only on a grant.
- req_wready[i] is combinational. It is high only in an IDLE cycle where i wins. That cycle is the accept handshake.
- On grant, AWADDR/AWLEN/AWSIZE/AWBURST are registered from slice i and AWID is registered as i, zero-extended.
- AW payload is held stable while AWVALID=1. AWVALID never drops without AWREADY.
- wr_outst:
  - +1 on AW handshake.
  - -1 on BVALID&BREADY.
  - Both in the same cycle: unchanged.
  - Decrement at 0: count stays 0, cnt_err is set, and wr_done still pulses.
- Read side: the decrement and rd_done/rd_err fire only on RVALID&RREADY&RLAST. rd_err reflects RRESP of the last beat.
- wr_done[BID] and wr_err[BID] are registered and pulse one cycle after the B handshake. A BID >= NUM_REQ produces no pulse but still decrements.

## Timing
- Reset values: all outputs 0; AWVALID/ARVALID 0; FSMs IDLE; counts 0; cnt_err 0.
- Grant at cycle T gives AWVALID=1 from T+1. With AWREADY=1 at T+1, the next grant is possible at T+2. Peak rate is one command per 2 cycles per direction.
- AW and AR may handshake in the same cycle.
- Credit limit: a grant requires count < MAX_OUTST in the grant cycle. A completion in that same cycle does not enable the grant; the count is evaluated registered.
- Completion pulse latency is 1 cycle after the handshake.
- Reset asserted mid-ISSUE: AWVALID drops asynchronously, the command is discarded, and counts clear.

## Test plan
- Reset: hold ARESETn=0 with random inputs. All outputs are 0. Release: first grant goes to requester 0.
- Fairness: all 4 req_wvalid high, AWREADY=1. Grants occur in order 0,1,2,3,0 on cycles T, T+2, T+4, T+6, T+8. AWID matches each grant.
- Backpressure: grant requester 2 with waddr=0x1000_0040 and AWREADY low for 5 cycles. AWADDR/AWID stay stable and AWVALID=1 throughout. One handshake occurs, and wr_outst=1.
- Credit limit: issue 15 writes with no B. The 16th req_wvalid gets no grant. One B handshake drops the count to 14, and the grant follows on the next IDLE evaluation.
- Simultaneous events: AW handshake and B handshake in the same cycle leave wr_outst unchanged. BID=2 with BRESP=2'b10 pulses wr_done[2] and wr_err[2] one cycle later.
- Read completion: a 4-beat read from requester 1 decrements rd_outst only on the RLAST beat, giving rd_done[1] once. An R handshake at rd_outst=0 sets cnt_err.
